frame_merge: RTL and testbench
==============================

# frame_merge

Transmit-side framer and merger for the network block. It accepts byte streams from the ARP transmitter and the UDP transmitter, prepends the Ethernet header (and the IPv4 and UDP headers for UDP traffic), and zero-pads to the Ethernet minimum of 60 bytes, FCS excluded. It drives a single valid/ready/last byte stream toward the MAC TX path, which appends the preamble and FCS.

## Interface
- LOCAL_IP, 32'hC0A8_006E, source IPv4 address.
- LOCAL_MAC, 48'hABCD_1234_5678, source MAC address.
- logic_clk  in  1  single clock for the whole block.
- logic_rst  in  1  synchronous, active-high reset.
- arp_tdata_in  in  8  ARP payload byte.
- arp_tvalid_in  in  1  ARP byte valid.
- arp_tready_out  out  1  ARP byte accepted.
- arp_tlast_in  in  1  last ARP payload byte.
- arp_dmac_in  in  48  destination MAC, sampled at grant.
- udp_tdata_in  in  8  UDP payload byte.
- udp_tvalid_in  in  1  UDP byte valid.
- udp_tready_out  out  1  UDP byte accepted.
- udp_tlast_in  in  1  last UDP payload byte.
- udp_len_in  in  16  payload byte count, sampled at grant.
- udp_dip_in  in  32  destination IP, sampled at grant.
- udp_dmac_in  in  48  destination MAC, sampled at grant.
- udp_sport_in, udp_dport_in  in  16 each  UDP ports, sampled at grant.
- net_tdata_out  out  8  frame byte toward the MAC.
- net_tvalid_out  out  1  frame byte valid.
- net_tready_in  in  1  MAC accepts the byte.
- net_tlast_out  out  1  last frame byte.

## Operation
- States: IDLE, ETH_HEAD, IP_HEAD, UDP_HEAD, PAYLOAD, PAD.
- Arbitration happens in IDLE only.
  - arp_tvalid_in wins over udp_tvalid_in when both are high.
  - The grant locks until the frame's tlast byte is accepted on the output.
- At grant, all sideband inputs of the selected source are registered. Sideband changes after that point are ignored.
- ETH_HEAD, 14 bytes: DA (MSB first), then LOCAL_MAC, then type.
  - Type is 0x0806 for ARP, which then goes to PAYLOAD.
  - Type is 0x0800 for UDP, which then goes to IP_HEAD.
- IP_HEAD, 20 bytes, in order:
  - 45, 00, total length = 28 + udp_len.
  - ID: a 16-bit counter that resets to 0 and increments after each UDP frame.
  - 40 00 (DF set), TTL 40, protocol 11, header checksum.
  - LOCAL_IP, then DIP.
- Header checksum: one's-complement sum of the ten 16-bit header words with the checksum word taken as 0; fold carries twice, then invert.
  - Computed sequentially during ETH_HEAD.
  - Must be stable before IP byte 10 is emitted.
- UDP_HEAD, 8 bytes: sport, dport, length = 8 + udp_len, checksum 0x0000.
- PAYLOAD: the granted source's bytes pass through. A byte is taken only when the output register can advance.
- Payload ends on the source's tlast. udp_len_in is trusted and not checked against the actual count.
- A 16-bit byte counter counts emitted frame bytes.
  - If the counter is below 60 at the source's tlast, the block enters PAD and emits 0x00 bytes until byte 60.
  - Otherwise that source byte is the frame end.
- net_tlast_out is asserted on exactly one byte: the final pad byte, or the final payload byte.
- After tlast is accepted, the block returns to IDLE.

## Timing
- Reset values: net_tdata_out=0, net_tvalid_out=0, net_tlast_out=0, arp_tready_out=0, udp_tready_out=0. IP ID=0, state=IDLE.
- The output is a single register stage. It advances when !net_tvalid_out || net_tready_in.
- While the output is stalled, data and last hold stable and no internal state advances.
- Source ready is combinational: high only in PAYLOAD for the granted source, AND the advance condition. The non-granted ready is always 0.
- Latency: a valid seen in IDLE at cycle N gives the first DA byte with net_tvalid_out at cycle N+1.
- With net_tready_in held high, the frame streams at one byte per cycle with no gaps, provided the source keeps tvalid high.
- A source tvalid gap in PAYLOAD deasserts net_tvalid_out for the matching cycles. Gaps are allowed, and the counter does not advance.
- There is at least one IDLE cycle between frames; the arbiter reevaluates in that cycle.
- Counter boundaries:
  - The byte counter saturates at 0xFFFF; wrap is not required.
  - The ID counter wraps from 0xFFFF to 0x0000.
- Reset mid-frame: the next edge clears all outputs. The partial frame is abandoned with no tlast, and source data is not drained.

## Test plan
- ARP frame:
  - Stimulus: 28 bytes, arp_dmac_in=FFFF_FFFF_FFFF, ready always high.
  - Response: 60 bytes. Bytes 0-5 are FF, bytes 6-11 are AB CD 12 34 56 78, bytes 12-13 are 08 06, then 28 payload bytes, then 18 zero bytes. tlast only on byte 59.
- UDP frame, first after reset:
  - Stimulus: udp_len=32, DIP C0A8_0064, 32 payload bytes.
  - Response: 74 bytes, no pad, type 0800. IP total length 003C, ID 0000, checksum B88E, UDP length 0028, checksum 0000. tlast on the last payload byte.
- Short UDP:
  - Stimulus: udp_len=4, i.e. 46 header+payload bytes.
  - Response: 14 zero pad bytes, tlast on byte 59. IP ID reads 0001 on the second UDP frame.
- Simultaneous request:
  - Stimulus: arp_tvalid_in and udp_tvalid_in rise in the same cycle.
  - Response: the ARP frame goes out in full first. udp_tready_out stays 0 throughout. The UDP frame starts after one IDLE cycle.
- Backpressure:
  - Stimulus: net_tready_in toggles randomly (pseudo-random pattern) during all states.
  - Response: the output byte sequence is identical to the ready-high case, and no byte changes while valid=1 and ready=0.
- Mid-frame reset:
  - Stimulus: assert logic_rst during PAYLOAD.
  - Response: all outputs 0 on the next cycle. A following ARP request produces a correct complete 60-byte frame.

Source files
------------

// File: rtl/frame_merge.sv
// Transmit framer: arbitrates ARP/UDP byte streams, prepends Ethernet/IPv4/UDP
// headers and zero-pads short frames to 60 bytes behind one output register.
`timescale 1ns/1ps
module frame_merge #(
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_006E,
  parameter logic [47:0] LOCAL_MAC = 48'hABCD_1234_5678
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [7:0]  arp_tdata_in,
  input  logic        arp_tvalid_in,
  output logic        arp_tready_out,
  input  logic        arp_tlast_in,
  input  logic [47:0] arp_dmac_in,
  input  logic [7:0]  udp_tdata_in,
  input  logic        udp_tvalid_in,
  output logic        udp_tready_out,
  input  logic        udp_tlast_in,
  input  logic [15:0] udp_len_in,
  input  logic [31:0] udp_dip_in,
  input  logic [47:0] udp_dmac_in,
  input  logic [15:0] udp_sport_in,
  input  logic [15:0] udp_dport_in,
  output logic [7:0]  net_tdata_out,
  output logic        net_tvalid_out,
  input  logic        net_tready_in,
  output logic        net_tlast_out
);

  typedef enum logic [2:0] {
    IDLE, ETH_HEAD, IP_HEAD, UDP_HEAD, PAYLOAD, PAD
  } state_t;

  state_t      state;
  logic        sel_udp;
  logic [4:0]  idx;
  logic [15:0] cnt;
  logic [15:0] ip_id;
  logic [15:0] len;
  logic [15:0] sport;
  logic [15:0] dport;
  logic [47:0] dmac;
  logic [31:0] dip;
  logic [19:0] csum;

  logic         adv;
  logic         src_valid;
  logic         src_last;
  logic [7:0]   src_data;
  logic [15:0]  cnt_nx;
  logic [16:0]  fold1;
  logic [15:0]  fold2;
  logic [15:0]  ck;
  logic [111:0] eth_hdr;
  logic [159:0] ip_base;
  logic [159:0] ip_hdr;
  logic [63:0]  udp_hdr;
  logic [4:0]   widx;
  logic [15:0]  ip_word;
  logic [7:0]   eth_byte;
  logic [7:0]   ip_byte;
  logic [7:0]   udp_byte;

  assign adv = !net_tvalid_out || net_tready_in;

  assign arp_tready_out = (state == PAYLOAD) && !sel_udp && adv;
  assign udp_tready_out = (state == PAYLOAD) && sel_udp && adv;

  assign src_valid = sel_udp ? udp_tvalid_in : arp_tvalid_in;
  assign src_last  = sel_udp ? udp_tlast_in : arp_tlast_in;
  assign src_data  = sel_udp ? udp_tdata_in : arp_tdata_in;

  assign cnt_nx = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // Header checksum accumulates during ETH_HEAD; folded here from a register
  assign fold1 = {1'b0, csum[15:0]} + {13'd0, csum[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};
  assign ck    = ~fold2;

  assign eth_hdr = {dmac, LOCAL_MAC, 8'h08, sel_udp ? 8'h00 : 8'h06};
  assign ip_base = {8'h45, 8'h00, len + 16'd28, ip_id, 16'h4000,
                    8'h40, 8'h11, 16'h0000, LOCAL_IP, dip};
  assign ip_hdr  = ip_base | {80'd0, ck, 64'd0};
  assign udp_hdr = {sport, dport, len + 16'd8, 16'h0000};

  assign widx     = idx - 5'd1;
  assign ip_word  = 16'(ip_base >> (9'd144 - {widx, 4'b0000}));
  assign eth_byte = 8'(eth_hdr >> (8'd104 - {idx, 3'b000}));
  assign ip_byte  = 8'(ip_hdr >> (8'd152 - {idx, 3'b000}));
  assign udp_byte = 8'(udp_hdr >> (8'd56 - {idx, 3'b000}));

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state          <= IDLE;
      sel_udp        <= 1'b0;
      idx            <= 5'd0;
      cnt            <= 16'd0;
      ip_id          <= 16'd0;
      len            <= 16'd0;
      sport          <= 16'd0;
      dport          <= 16'd0;
      dmac           <= 48'd0;
      dip            <= 32'd0;
      csum           <= 20'd0;
      net_tdata_out  <= 8'd0;
      net_tvalid_out <= 1'b0;
      net_tlast_out  <= 1'b0;
    end else if (adv) begin
      unique case (state)
        IDLE: begin
          net_tlast_out <= 1'b0;
          // The cycle that retires the last byte is the mandatory idle gap
          if (net_tvalid_out) begin
            net_tvalid_out <= 1'b0;
          end else if (arp_tvalid_in || udp_tvalid_in) begin
            sel_udp        <= !arp_tvalid_in;
            dmac           <= arp_tvalid_in ? arp_dmac_in : udp_dmac_in;
            net_tdata_out  <= arp_tvalid_in ? arp_dmac_in[47:40]
                                            : udp_dmac_in[47:40];
            len            <= udp_len_in;
            dip            <= udp_dip_in;
            sport          <= udp_sport_in;
            dport          <= udp_dport_in;
            csum           <= 20'd0;
            idx            <= 5'd1;
            cnt            <= 16'd1;
            net_tvalid_out <= 1'b1;
            state          <= ETH_HEAD;
          end
        end
        ETH_HEAD: begin
          net_tdata_out <= eth_byte;
          cnt           <= cnt_nx;
          if (idx <= 5'd10) csum <= csum + {4'd0, ip_word};
          if (idx == 5'd13) begin
            idx   <= 5'd0;
            state <= sel_udp ? IP_HEAD : PAYLOAD;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        IP_HEAD: begin
          net_tdata_out <= ip_byte;
          cnt           <= cnt_nx;
          if (idx == 5'd19) begin
            idx   <= 5'd0;
            state <= UDP_HEAD;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        UDP_HEAD: begin
          net_tdata_out <= udp_byte;
          cnt           <= cnt_nx;
          if (idx == 5'd7) begin
            idx   <= 5'd0;
            state <= PAYLOAD;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        PAYLOAD: begin
          net_tvalid_out <= src_valid;
          if (src_valid) begin
            net_tdata_out <= src_data;
            cnt           <= cnt_nx;
            if (src_last) begin
              if (cnt < 16'd59) begin
                state <= PAD;
              end else begin
                net_tlast_out <= 1'b1;
                state         <= IDLE;
                if (sel_udp) ip_id <= ip_id + 16'd1;
              end
            end
          end
        end
        PAD: begin
          net_tdata_out <= 8'h00;
          cnt           <= cnt_nx;
          if (cnt >= 16'd59) begin
            net_tlast_out <= 1'b1;
            state         <= IDLE;
            if (sel_udp) ip_id <= ip_id + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_merge.sv
// Scoreboard bench for frame_merge: random ARP/UDP frames, backpressure,
// arbitration and mid-frame reset against a byte-level frame model.
`timescale 1ns/1ps
module tb_frame_merge;

  localparam logic [47:0] LMAC = 48'hABCD_1234_5678;
  localparam logic [31:0] LIP  = 32'hC0A8_006E;

  logic        logic_clk;
  logic        logic_rst;
  logic [7:0]  arp_tdata_in;
  logic        arp_tvalid_in;
  logic        arp_tready_out;
  logic        arp_tlast_in;
  logic [47:0] arp_dmac_in;
  logic [7:0]  udp_tdata_in;
  logic        udp_tvalid_in;
  logic        udp_tready_out;
  logic        udp_tlast_in;
  logic [15:0] udp_len_in;
  logic [31:0] udp_dip_in;
  logic [47:0] udp_dmac_in;
  logic [15:0] udp_sport_in;
  logic [15:0] udp_dport_in;
  logic [7:0]  net_tdata_out;
  logic        net_tvalid_out;
  logic        net_tready_in;
  logic        net_tlast_out;

  typedef struct packed {
    logic       udp;
    logic       last;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] arp_pl[$];
  logic [7:0] udp_pl[$];
  int         errors = 0;
  int         checks = 0;
  int         popped = 0;
  bit         mon_en = 0;
  bit         abort = 0;
  bit         gap_en = 0;
  bit         bp_en = 0;
  bit         chk_rdy = 0;
  logic [15:0] model_id = 16'd0;

  bit         hp = 0;
  bit         al = 0;
  logic [7:0] hd;
  logic       hl;
  exp_t       me;

  frame_merge dut (
    .logic_clk      (logic_clk),
    .logic_rst      (logic_rst),
    .arp_tdata_in   (arp_tdata_in),
    .arp_tvalid_in  (arp_tvalid_in),
    .arp_tready_out (arp_tready_out),
    .arp_tlast_in   (arp_tlast_in),
    .arp_dmac_in    (arp_dmac_in),
    .udp_tdata_in   (udp_tdata_in),
    .udp_tvalid_in  (udp_tvalid_in),
    .udp_tready_out (udp_tready_out),
    .udp_tlast_in   (udp_tlast_in),
    .udp_len_in     (udp_len_in),
    .udp_dip_in     (udp_dip_in),
    .udp_dmac_in    (udp_dmac_in),
    .udp_sport_in   (udp_sport_in),
    .udp_dport_in   (udp_dport_in),
    .net_tdata_out  (net_tdata_out),
    .net_tvalid_out (net_tvalid_out),
    .net_tready_in  (net_tready_in),
    .net_tlast_out  (net_tlast_out)
  );

  initial logic_clk = 1'b0;
  always #5 logic_clk = ~logic_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected frame built straight from the frame layout rules
  task automatic push_frame(input bit udp, input logic [47:0] dmac,
                            input logic [15:0] len, input logic [31:0] dip,
                            input logic [15:0] sp, input logic [15:0] dp);
    logic [7:0]  f[$];
    logic [15:0] w[10];
    logic [47:0] m;
    logic [31:0] ip;
    logic [15:0] ul;
    int          s;
    exp_t        e;
    m = LMAC;
    ip = LIP;
    for (int k = 0; k < 6; k++) f.push_back(dmac[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) f.push_back(m[47-8*k -: 8]);
    f.push_back(8'h08);
    f.push_back(udp ? 8'h00 : 8'h06);
    if (udp) begin
      w = '{16'h4500, len + 16'd28, model_id, 16'h4000, 16'h4011,
            16'h0000, ip[31:16], ip[15:0], dip[31:16], dip[15:0]};
      s = 0;
      for (int k = 0; k < 10; k++) s += int'(w[k]);
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      w[5] = ~s[15:0];
      for (int k = 0; k < 10; k++) begin
        f.push_back(w[k][15:8]);
        f.push_back(w[k][7:0]);
      end
      ul = len + 16'd8;
      f.push_back(sp[15:8]);
      f.push_back(sp[7:0]);
      f.push_back(dp[15:8]);
      f.push_back(dp[7:0]);
      f.push_back(ul[15:8]);
      f.push_back(ul[7:0]);
      f.push_back(8'h00);
      f.push_back(8'h00);
      model_id = model_id + 16'd1;
      foreach (udp_pl[k]) f.push_back(udp_pl[k]);
    end else begin
      foreach (arp_pl[k]) f.push_back(arp_pl[k]);
    end
    while (f.size() < 60) f.push_back(8'h00);
    foreach (f[k]) begin
      e.udp = udp;
      e.last = (k == f.size() - 1);
      e.d = f[k];
      sb.push_back(e);
    end
  endtask

  task automatic prep(input bit udp, input int n, input logic [47:0] dmac,
                      input logic [31:0] dip);
    logic [15:0] sp;
    logic [15:0] dp;
    sp = 16'($urandom);
    dp = 16'($urandom);
    if (udp) begin
      udp_pl.delete();
      repeat (n) udp_pl.push_back(8'($urandom));
      udp_dmac_in = dmac;
      udp_len_in = 16'(n);
      udp_dip_in = dip;
      udp_sport_in = sp;
      udp_dport_in = dp;
    end else begin
      arp_pl.delete();
      repeat (n) arp_pl.push_back(8'($urandom));
      arp_dmac_in = dmac;
    end
    push_frame(udp, dmac, 16'(n), dip, sp, dp);
  endtask

  task automatic send(input bit udp);
    int n;
    int g;
    bit ok;
    n = udp ? udp_pl.size() : arp_pl.size();
    for (int i = 0; i < n && !abort; i++) begin
      if (gap_en && $urandom_range(3) == 0) begin
        if (udp) udp_tvalid_in = 1'b0;
        else arp_tvalid_in = 1'b0;
        @(posedge logic_clk);
        #1;
      end
      if (udp) begin
        udp_tdata_in = udp_pl[i];
        udp_tlast_in = (i == n - 1);
        udp_tvalid_in = 1'b1;
      end else begin
        arp_tdata_in = arp_pl[i];
        arp_tlast_in = (i == n - 1);
        arp_tvalid_in = 1'b1;
      end
      ok = 0;
      g = 0;
      while (!ok && !abort && g < 5000) begin
        @(negedge logic_clk);
        ok = udp ? udp_tready_out : arp_tready_out;
        @(posedge logic_clk);
        #1;
        g++;
      end
      if (!ok && !abort) begin
        checks++;
        errors++;
        $display("FAIL src_handshake: no ready after %0d cycles, need 1", g);
        break;
      end
      // Sideband must already be latched; scramble it to prove that
      if (i == 0) begin
        if (udp) begin
          udp_dmac_in = {16'($urandom), $urandom()};
          udp_len_in = 16'($urandom);
          udp_dip_in = $urandom();
          udp_sport_in = 16'($urandom);
          udp_dport_in = 16'($urandom);
        end else begin
          arp_dmac_in = {16'($urandom), $urandom()};
        end
      end
    end
    if (udp) begin
      udp_tvalid_in = 1'b0;
      udp_tlast_in = 1'b0;
    end else begin
      arp_tvalid_in = 1'b0;
      arp_tlast_in = 1'b0;
    end
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 4000) begin
      @(negedge logic_clk);
      g++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL frame_timeout: %0d bytes left, need 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge logic_clk);
    #1;
  endtask

  task automatic run_frame(input bit udp, input int n,
                           input logic [47:0] dmac, input logic [31:0] dip);
    prep(udp, n, dmac, dip);
    send(udp);
    wait_done();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, 64'(net_tdata_out), 64'd0);
    check({tag, "_valid"}, 64'(net_tvalid_out), 64'd0);
    check({tag, "_last"}, 64'(net_tlast_out), 64'd0);
    check({tag, "_arp_rdy"}, 64'(arp_tready_out), 64'd0);
    check({tag, "_udp_rdy"}, 64'(udp_tready_out), 64'd0);
  endtask

  initial begin
    net_tready_in = 1'b1;
    forever begin
      @(posedge logic_clk);
      #1;
      net_tready_in = bp_en ? ($urandom_range(2) != 0) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge logic_clk);
      if (!mon_en) begin
        hp = 0;
        al = 0;
      end else begin
        if (hp)
          check("stall_hold", 64'({net_tvalid_out, net_tlast_out, net_tdata_out}),
                64'({1'b1, hl, hd}));
        if (al) check("idle_gap", 64'(net_tvalid_out), 64'd0);
        al = 0;
        hp = net_tvalid_out && !net_tready_in;
        hd = net_tdata_out;
        hl = net_tlast_out;
        if (net_tvalid_out && net_tready_in) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %h, need no byte", net_tdata_out);
          end else begin
            me = sb.pop_front();
            check("frame_byte", 64'({net_tlast_out, net_tdata_out}),
                  64'({me.last, me.d}));
            popped++;
          end
          al = net_tlast_out;
        end
        if (chk_rdy && sb.size() > 0 && !sb[0].udp)
          check("udp_rdy_locked", 64'(udp_tready_out), 64'd0);
      end
    end
  end

  initial begin
    int p0;
    int g;
    logic_rst = 1'b1;
    arp_tdata_in = 8'd0;
    arp_tvalid_in = 1'b0;
    arp_tlast_in = 1'b0;
    arp_dmac_in = 48'd0;
    udp_tdata_in = 8'd0;
    udp_tvalid_in = 1'b0;
    udp_tlast_in = 1'b0;
    udp_len_in = 16'd0;
    udp_dip_in = 32'd0;
    udp_dmac_in = 48'd0;
    udp_sport_in = 16'd0;
    udp_dport_in = 16'd0;
    repeat (3) @(posedge logic_clk);
    #1;
    logic_rst = 1'b0;
    mon_en = 1;
    @(negedge logic_clk);
    check_zero("reset");
    @(posedge logic_clk);
    #1;

    run_frame(0, 28, 48'hFFFF_FFFF_FFFF, 32'd0);
    run_frame(1, 32, 48'h0011_2233_4455, 32'hC0A8_0064);
    run_frame(1, 4, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0001);

    prep(0, 20, 48'h1111_2222_3333, 32'd0);
    prep(1, 50, 48'h4444_5555_6666, 32'h0A00_0002);
    chk_rdy = 1;
    fork
      send(0);
      send(1);
    join
    wait_done();
    chk_rdy = 0;

    bp_en = 1;
    gap_en = 1;
    for (int f = 0; f < 8; f++)
      run_frame(1'($urandom_range(1)), $urandom_range(1, 80),
                {16'($urandom), $urandom()}, $urandom());
    bp_en = 0;
    gap_en = 0;

    prep(1, 40, 48'h0102_0304_0506, 32'hC0A8_0002);
    p0 = popped;
    fork
      send(1);
      begin
        g = 0;
        while (popped - p0 < 50 && g < 2000) begin
          @(negedge logic_clk);
          g++;
        end
        @(posedge logic_clk);
        #1;
        mon_en = 0;
        abort = 1;
        logic_rst = 1'b1;
        @(posedge logic_clk);
        @(negedge logic_clk);
        check_zero("midrst");
        @(posedge logic_clk);
        #1;
        logic_rst = 1'b0;
      end
    join
    abort = 0;
    sb.delete();
    model_id = 16'd0;
    mon_en = 1;
    @(posedge logic_clk);
    #1;
    run_frame(0, 28, 48'hFFFF_FFFF_FFFF, 32'd0);
    run_frame(1, 10, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
